// File: rtl/hpi_burst_engine.sv
// rtl/hpi_burst_engine.sv - timed single/burst read, write and chip-reset sequencer for the CY7C67200 HPI
// Every pin is driven from a register loaded with the value implied by the next state.
module hpi_burst_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int LEN_W      = 4,
  parameter int RESET_CYC  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] otg_hpi_address,
  output logic              otg_hpi_cs_n,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic              otg_hpi_reset_n,
  input  logic [DATA_W-1:0] otg_hpi_data_in,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe
);

  localparam int M1    = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2    = (HOLD_CYC > RESET_CYC) ? HOLD_CYC : RESET_CYC;
  localparam int MAXC  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_STROBE, S_HOLD, S_DRAIN, S_RST
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               cmd_ready_q, wr_ready_q, busy_q;
  logic               cs_n_q, r_n_q, w_n_q, reset_n_q, oe_q;
  logic               pin_active_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q & ~rd_ready;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          case (cmd_op)
            OP_RD: begin
              state_d = S_SETUP;
              cnt_d   = CNT_W'(SETUP_CYC - 1);
            end
            OP_WR:  state_d = S_FETCH;
            OP_RST: begin
              state_d = S_RST;
              cnt_d   = CNT_W'(RESET_CYC - 1);
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_FETCH: begin
        if (wr_valid) begin
          data_d  = wr_data;
          state_d = S_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          if (op_q == OP_RD) begin
            rd_data_d  = otg_hpi_data_in;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (rem_q == '0) begin
            state_d = S_IDLE;
          end else begin
            rem_d = rem_q - LEN_W'(1);
            if (op_q == OP_WR) begin
              state_d = S_FETCH;
            end else if (rd_valid_q) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_SETUP;
              cnt_d   = CNT_W'(SETUP_CYC - 1);
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Park with CS released until the previous word has left, so rd_data is never overwritten.
        if (rd_valid_q && rd_ready) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_RST: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pin_active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      reset_n_q   <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      cmd_ready_q <= (state_d == S_IDLE);
      wr_ready_q  <= (state_d == S_FETCH);
      busy_q      <= (state_d != S_IDLE);
      cs_n_q      <= ~pin_active_d;
      r_n_q       <= ~((state_d == S_STROBE) && (op_d == OP_RD));
      w_n_q       <= ~((state_d == S_STROBE) && (op_d == OP_WR));
      reset_n_q   <= (state_d != S_RST);
      oe_q        <= pin_active_d && (op_d == OP_WR);
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign wr_ready         = wr_ready_q;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign busy             = busy_q;
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_cs_n     = cs_n_q;
  assign otg_hpi_r_n      = r_n_q;
  assign otg_hpi_w_n      = w_n_q;
  assign otg_hpi_reset_n  = reset_n_q;
  assign otg_hpi_data_out = data_q;
  assign otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_hpi_burst_engine.sv
// tb/tb_hpi_burst_engine.sv - directed self-checking bench for hpi_burst_engine
// Inputs change and outputs are sampled on the falling edge; a posedge monitor logs pin pulses.
module tb_hpi_burst_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'b00;
  logic [3:0]  cmd_len = 4'h0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'h0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        busy;
  logic [1:0]  address;
  logic        cs_n, r_n, w_n, chip_rst_n, oe;
  logic [15:0] data_in = 16'h0;
  logic [15:0] data_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hpi_burst_engine dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .busy             (busy),
    .otg_hpi_address  (address),
    .otg_hpi_cs_n     (cs_n),
    .otg_hpi_r_n      (r_n),
    .otg_hpi_w_n      (w_n),
    .otg_hpi_reset_n  (chip_rst_n),
    .otg_hpi_data_in  (data_in),
    .otg_hpi_data_out (data_out),
    .otg_hpi_data_oe  (oe)
  );

  // Pin monitor: pulse counts, strobe widths, per-pulse data/address and delivered read words.
  int rn_pulses = 0, wn_pulses = 0, rn_w = 0, wn_w = 0, bad_width = 0;
  int cs_low = 0, rst_low = 0, rcnt = 0;
  logic rn_prev = 1'b1, wn_prev = 1'b1;
  logic [15:0] wlog [0:31];
  logic [1:0]  alog [0:31];
  logic [15:0] rlog [0:31];

  always @(posedge clk) begin
    rn_prev <= r_n;
    wn_prev <= w_n;
    if (!cs_n) cs_low <= cs_low + 1;
    if (!chip_rst_n) rst_low <= rst_low + 1;
    if (!r_n && rn_prev) rn_pulses <= rn_pulses + 1;
    if (!r_n) rn_w <= rn_w + 1;
    else begin
      if (!rn_prev && rn_w != 4) bad_width <= bad_width + 1;
      rn_w <= 0;
    end
    if (!w_n && wn_prev) begin
      wn_pulses <= wn_pulses + 1;
      wlog[wn_pulses[4:0]] <= data_out;
      alog[wn_pulses[4:0]] <= address;
    end
    if (!w_n) wn_w <= wn_w + 1;
    else begin
      if (!wn_prev && wn_w != 4) bad_width <= bad_width + 1;
      wn_w <= 0;
    end
    if (rd_valid && rd_ready) begin
      rlog[rcnt[4:0]] <= rd_data;
      rcnt <= rcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return busy === 1'b0;
      1:       return wr_ready === 1'b1;
      2:       return rd_valid === 1'b1;
      3:       return w_n === 1'b0;
      default: return cmd_ready === 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string tag);
    int k = 0;
    while (!cond(sel) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, cond(sel)}, 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] len);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int b_wn, b_rn, b_rc, b_cs, b_rst, b_bad;
  logic prev_cs;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pins", {cs_n, r_n, w_n, chip_rst_n, oe}, 5'b11110);
    chk("rst_addr_data", {address, data_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Single read: accept at cycle 0, check pin timeline for cycles 1..9.
    b_bad = bad_width;
    cmd_op = 2'b00; cmd_addr = 2'd2; cmd_len = 4'h0; cmd_valid = 1'b1;
    data_in = 16'hBEEF; rd_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      chk($sformatf("rd1_cs_n_c%0d", c), cs_n, (c <= 8) ? 1'b0 : 1'b1);
      chk($sformatf("rd1_r_n_c%0d", c), r_n, (c >= 3 && c <= 6) ? 1'b0 : 1'b1);
      chk($sformatf("rd1_rd_valid_c%0d", c), rd_valid, (c == 7) ? 1'b1 : 1'b0);
      chk($sformatf("rd1_busy_c%0d", c), busy, (c <= 8) ? 1'b1 : 1'b0);
      chk($sformatf("rd1_addr_c%0d", c), address, 2'd2);
      if (c == 7) chk("rd1_rd_data", rd_data, 16'hBEEF);
    end

    // Write burst of 4 with a 5-cycle stall before the third word.
    b_wn = wn_pulses;
    send_cmd(2'b01, 2'd1, 4'd3);
    for (int w = 0; w < 4; w++) begin
      wait_until(1, 60, $sformatf("wrb_wr_ready_w%0d", w));
      if (w == 2) begin
        for (int s = 0; s < 5; s++) begin
          chk($sformatf("wrb_stall_cs_n_s%0d", s), cs_n, 1);
          chk($sformatf("wrb_stall_oe_s%0d", s), oe, 0);
          @(negedge clk);
        end
      end
      wr_data = 16'(w + 1); wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
    end
    wait_until(0, 60, "wrb_idle");
    @(negedge clk);
    chk("wrb_pulses", wn_pulses - b_wn, 4);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("wrb_data_w%0d", w), wlog[(b_wn + w) % 32], 16'(w + 1));
      chk($sformatf("wrb_addr_w%0d", w), alog[(b_wn + w) % 32], 2'd1);
    end

    // Read burst of 2 with the consumer stalled after the first word.
    rd_ready = 1'b0; data_in = 16'h1111;
    b_rn = rn_pulses; b_rc = rcnt;
    send_cmd(2'b00, 2'd3, 4'd1);
    wait_until(2, 30, "rdb_first_valid");
    chk("rdb_first_data", rd_data, 16'h1111);
    data_in = 16'h2222;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 20; s++) begin
      chk($sformatf("rdb_drain_cs_n_s%0d", s), cs_n, 1);
      chk($sformatf("rdb_drain_busy_s%0d", s), busy, 1);
      @(negedge clk);
    end
    chk("rdb_one_strobe", rn_pulses - b_rn, 1);
    rd_ready = 1'b1;
    wait_until(0, 40, "rdb_idle");
    @(negedge clk);
    chk("rdb_strobes", rn_pulses - b_rn, 2);
    chk("rdb_words", rcnt - b_rc, 2);
    chk("rdb_word0", rlog[b_rc % 32], 16'h1111);
    chk("rdb_word1", rlog[(b_rc + 1) % 32], 16'h2222);

    // Chip reset op, then reserved op.
    b_cs = cs_low; b_rst = rst_low; b_rn = rn_pulses; b_wn = wn_pulses;
    send_cmd(2'b10, 2'd0, 4'd0);
    wait_until(0, 40, "crst_idle");
    @(negedge clk);
    chk("crst_low_cycles", rst_low - b_rst, 16);
    chk("crst_no_cs", cs_low - b_cs, 0);
    chk("crst_no_strobe", (rn_pulses - b_rn) + (wn_pulses - b_wn), 0);
    chk("rsv_cmd_ready", cmd_ready, 1);
    send_cmd(2'b11, 2'd2, 4'd5);
    chk("rsv_busy", busy, 0);
    chk("rsv_cmd_ready_after", cmd_ready, 1);
    repeat (4) @(negedge clk);
    chk("rsv_no_cs", cs_low - b_cs, 0);
    chk("rsv_no_reset", rst_low - b_rst, 16);

    // Maximum read burst, then a back-to-back write.
    b_rn = rn_pulses; b_rc = rcnt; b_wn = wn_pulses;
    rd_ready = 1'b1; data_in = 16'h5A5A;
    send_cmd(2'b00, 2'd0, 4'hF);
    begin
      int k = 0;
      prev_cs = cs_n;
      while (cmd_ready !== 1'b1 && k < 400) begin
        prev_cs = cs_n;
        @(negedge clk);
        k++;
      end
    end
    chk("max_ready_after_hold", {prev_cs, cs_n, cmd_ready}, 3'b011);
    send_cmd(2'b01, 2'd3, 4'd0);
    chk("b2b_accepted", busy, 1);
    wait_until(1, 10, "b2b_wr_ready");
    wr_data = 16'hA5A5; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_until(0, 40, "b2b_idle");
    @(negedge clk);
    chk("max_strobes", rn_pulses - b_rn, 16);
    chk("max_words", rcnt - b_rc, 16);
    chk("b2b_pulses", wn_pulses - b_wn, 1);
    chk("b2b_data", wlog[b_wn % 32], 16'hA5A5);
    chk("strobe_widths", bad_width - b_bad, 0);

    // Asynchronous reset during a write strobe.
    send_cmd(2'b01, 2'd1, 4'd0);
    wait_until(1, 10, "arst_wr_ready");
    wr_data = 16'h7777; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_until(3, 20, "arst_in_strobe");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_pins", {w_n, cs_n, oe}, 3'b110);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_quiet", {cs_n, w_n, r_n}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hpi_burst_engine.md
Name: hpi_burst_engine

Overview:
- Hardware sequencer for the CY7C67200 OTG Host Port Interface (HPI). It replaces the CPU bit-banged PIO exports with timed, single-word or burst read, write and chip-reset transactions.
- Sits between a command/stream interface (fed by the SoC or a DMA) and the otg_hpi_* pins.
- Timing is parametrised. Bursts hold the HPI address constant; the chip auto-increments internally.

Parameters:
- DATA_W, 16: HPI data width.
- ADDR_W, 2: HPI address width.
- SETUP_CYC, 2: cycles with CS/address valid before the R/W strobe; must be ≥1.
- STROBE_CYC, 4: cycles R_N or W_N is held low; must be ≥1.
- HOLD_CYC, 2: cycles CS/address/data held after the strobe deasserts; must be ≥1.
- LEN_W, 4: burst length field width; maximum burst is 2^LEN_W words.
- RESET_CYC, 16: otg_hpi_reset_n low time for a chip-reset command.

Ports:
- clk_clk, in, 1: clock.
- reset_reset_n, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid & cmd_ready.
- cmd_op, in, 2: 00 read, 01 write, 10 chip reset, 11 reserved.
- cmd_addr, in, ADDR_W: HPI register address.
- cmd_len, in, LEN_W: burst length minus 1 (0 = 1 word).
- wr_valid, in, 1: write data word available.
- wr_ready, out, 1: write word consumed.
- wr_data, in, DATA_W: write data.
- rd_valid, out, 1: read data word valid.
- rd_ready, in, 1: read consumer ready.
- rd_data, out, DATA_W: read data.
- busy, out, 1: high whenever the FSM is not in IDLE.
- otg_hpi_address, out, ADDR_W: HPI address.
- otg_hpi_cs_n, out, 1: chip select, active low.
- otg_hpi_r_n, out, 1: read strobe, active low.
- otg_hpi_w_n, out, 1: write strobe, active low.
- otg_hpi_reset_n, out, 1: chip reset, active low.
- otg_hpi_data_in, in, DATA_W: data from the pad.
- otg_hpi_data_out, out, DATA_W: data to the pad.
- otg_hpi_data_oe, out, 1: pad output enable.

Behaviour:
- Reset values:
  - cmd_ready=0, busy=0, wr_ready=0, rd_valid=0, rd_data=0.
  - cs_n=r_n=w_n=reset_n=1, address=0, data_out=0, data_oe=0.
  - FSM in IDLE, counters cleared.
- All pin outputs are registered; there are no combinational paths from inputs to pins.
- cmd_ready=1 only in IDLE. A handshake latches op, addr and remaining=cmd_len. Next state: read→SETUP; write→FETCH; chip reset→RST; reserved op is accepted and discarded (stays IDLE).
- FETCH (write only):
  - wr_ready=1, cs_n=1.
  - On wr_valid, latch wr_data into the data register and go to SETUP.
  - A stall of any length is allowed.
- SETUP, SETUP_CYC cycles:
  - cs_n=0, address driven.
  - For writes, data_oe=1 and data_out=latched word.
- STROBE, STROBE_CYC cycles:
  - r_n=0 (read) or w_n=0 (write); cs_n stays 0.
  - Read: otg_hpi_data_in is captured on the last STROBE cycle's edge into rd_data, and rd_valid is set the following cycle.
- HOLD, HOLD_CYC cycles:
  - strobes=1, cs_n=0, write data and oe still driven.
  - At exit, cs_n=1 and data_oe=0 in the same cycle.
- After HOLD:
  - If remaining==0 → IDLE.
  - Else decrement remaining. Write → FETCH. Read → SETUP if rd_valid==0, else DRAIN.
- DRAIN: cs_n=1; wait until rd_valid & rd_ready, then → SETUP.
- rd_valid clears on rd_ready. A set and a clear in the same cycle give priority to set; this cannot occur by construction.
- Read latency, single word: accept at cycle T; rd_valid first high at T+SETUP_CYC+STROBE_CYC+1.
- Write: one pin cycle per word takes SETUP_CYC+STROBE_CYC+HOLD_CYC cycles plus ≥1 FETCH cycle.
- RST: reset_n=0 for RESET_CYC cycles, cs_n=1, then → IDLE.
- Burst of 2^LEN_W words (cmd_len all ones): remaining counts down without wrap; exactly 2^LEN_W strobes are issued.
- Asynchronous reset mid-transaction: all pins return to idle immediately, in-flight data is dropped, FSM goes to IDLE. No partial strobe resumes.
- cmd_valid while busy is ignored until IDLE. Inputs other than wr_data, cmd_* and otg_hpi_data_in are don't-care outside their handshake windows.

Test Plan:
- Reset during STROBE of a write → same cycle: w_n=1, cs_n=1, data_oe=0, busy=0; after release cmd_ready=1.
- Read, addr=2, len=0, data_in=16'hBEEF, rd_ready=1 → with defaults (accept T=0): cs_n low cycles 1–8, r_n low 3–6, rd_valid=1 at cycle 7 with rd_data=BEEF, busy=0 at cycle 9.
- Write burst, len=3, wr_data 1,2,3,4 with wr_valid stalled 5 cycles before word 3 → exactly 4 w_n pulses of 4 cycles each, data_out matches each pulse, address constant 1, cs_n high during the stall.
- Read burst, len=1, rd_ready=0 for 20 cycles after the first word → FSM parks in DRAIN with cs_n=1 and no second r_n pulse. Releasing rd_ready produces the second strobe; two words are delivered in order.
- Chip reset op → reset_n low exactly 16 cycles, no cs_n/r_n/w_n activity, then IDLE. A reserved op=11 → accepted, no pin activity.
- Max burst, cmd_len=4'hF, read → exactly 16 r_n pulses, then IDLE. Follow with a back-to-back command → cmd_ready reasserts the cycle after the final HOLD.
